uart_rx: RTL and testbench
==========================

# uart_rx

UART receive engine driving the CPU's `cpu_uart_rxd` pin: 8N1 framing, LSB first, mid-bit sampling against a clock-cycle bit timer. Received bytes are queued in a show-ahead FIFO and popped by the consumer over a valid/ready handshake. Sits between the top-level `cpu_uart_rxd` pad and the CPU-side I/O load path; counterpart of the host-side transmitter.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per bit (100 MHz / 115200); legal range ≥ 4.
- `FIFO_DEPTH`, 16, receive FIFO entries; power of two, ≥ 2.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rxd`  in  1  asynchronous serial input; idle high.
- `rdata`  out  8  FIFO head byte; 8'h00 whenever `rvalid`=0.
- `rvalid`  out  1  FIFO non-empty.
- `rready`  in  1  consumer accept; pop when `rvalid && rready`.
- `busy`  out  1  frame in progress (state ≠ IDLE).
- `overrun`  out  1  one-cycle pulse: completed byte dropped because FIFO full.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0.
- `parity_err`  out  1  one-cycle pulse: parity mismatch (tied 0 without `UART_RX_PARITY_EN`).

## Operation
- Input: 2-flop synchronizer on `rxd`, both flops reset to 1; plus previous-sample flop for edge detect.
- Arm flag: cleared by reset; set on first synchronized high sample. Start detection requires arm=1 (no false start from a line held low through reset).
- Bit counter width `$clog2(CLKS_PER_BIT)`; bit index 3 bits.
- States: IDLE → START → DATA → (PARITY) → STOP → IDLE.
- IDLE: falling edge (prev 1, now 0) with arm=1 → START, counter=0.
- START: at counter = CLKS_PER_BIT/2 − 1 (floor) sample; 0 → DATA, counter=0; 1 → IDLE (glitch rejected, no flag).
- DATA: sample at counter = CLKS_PER_BIT − 1, shift into bit[index], index 0..7; after bit 7 → PARITY (macro on) or STOP.
- PARITY: sample at full bit period; compare against even parity of data; keep mismatch flag.
- STOP: sample at full bit period, then IDLE in the same cycle (half-bit early resync).
  - sample 1, no parity mismatch: push byte.
  - sample 0: `frame_err` pulse, byte dropped; parity check ignored.
  - sample 1 with mismatch: `parity_err` pulse, byte dropped.
- A line still low after a frame error starts no new frame until a rising then falling edge.
- FIFO: read/write pointers of `$clog2(FIFO_DEPTH)`+1 bits; full/empty from pointer MSB compare.
  - Push when full and no simultaneous pop: byte dropped, `overrun` pulse.
  - Push and pop in the same cycle when full: both occur, no overrun; count unchanged.
  - Pop when empty: ignored.
- Reset (any time, including mid-frame): state IDLE, arm=0, FIFO empty, all outputs 0 (`rdata`=8'h00, `busy`=0) from the next edge.

## Timing
- Pin to synchronized sample: 2 cycles.
- Start-edge detect to first data sample: CLKS_PER_BIT/2 + CLKS_PER_BIT cycles.
- Push at stop-sample cycle S; `rvalid`=1 and `rdata` valid at S+1 (FIFO previously empty).
- Pop at cycle P; next head is visible at P+1; `rvalid` falls at P+1 if emptied.
- `frame_err`, `parity_err`, `overrun`: asserted exactly in cycle S+1, one cycle wide.
- `busy` rises the cycle after the start edge and falls at S+1.
- Sustained back-to-back frames are received at line rate with no gap required.

## Configuration
- `UART_RX_PARITY_EN` defined: 8E1 framing; PARITY state present, `parity_err` live.
- Undefined: 8N1; PARITY state and checker removed; `parity_err` constant 0.

## Test plan
- CLKS_PER_BIT=8, `rready`=1; send frames 0x55 then 0xA3 back to back -> `rvalid` pulses one cycle each, `rdata` 0x55 then 0xA3, no error flags.
- `rxd` low for 2 cycles, then high -> START aborts, `busy` pulses then falls, no push, no flags.
- Send 0x3C with stop bit 0, hold `rxd` low 40 cycles, release, send 0x81 -> single `frame_err` pulse, nothing pushed during low, then 0x81 received.
- `rready`=0; send 17 frames 0x00..0x10 -> single `overrun` pulse at 17th; draining yields 0x00..0x0F, then `rvalid`=0; also full + simultaneous pop/push -> no overrun.
- Macro on: 0x07 with parity 1 -> accepted; 0x07 with parity 0 -> `parity_err` pulse, no push.
- Assert `reset` after 3 data bits with `rxd` low -> `busy`=0, `rvalid`=0 next cycle, no false start; subsequent 0xF0 frame received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: UART receive engine with a show-ahead byte FIFO.
// Frames are 8N1 by default. With UART_RX_PARITY_EN defined, frames are 8E1:
// a PARITY state is added and parity_err becomes live.
// The serial input is synchronised, sampled mid-bit against a cycle timer,
// and completed bytes are queued for a valid/ready consumer.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rdata,
    output logic       rvalid,
    input  logic       rready,
    output logic       busy,
    output logic       overrun,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          r_state, r_state_next;
    logic            r_sync1, r_sync2, r_prev;
    logic [1:0]      r_vld;
    logic            r_arm;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_data;
`ifdef UART_RX_PARITY_EN
    logic            r_par_bad;
`endif
    logic            r_overrun, r_frame_err, r_parity_err;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW:0]     r_wptr, r_rptr;

    logic            w_fall, w_tick_half, w_tick_full;
    logic            w_busy, w_sample, w_push_req, w_ferr_set, w_perr_set;
    logic            w_full, w_empty, w_pop, w_push;

    // Synchroniser, edge-detect history and arm flag. r_vld marks when r_sync2
    // holds a real pin sample rather than its reset value, so a line held low
    // through reset can never arm the receiver.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_vld   <= 2'b00;
            r_arm   <= 1'b0;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_vld   <= {r_vld[0], 1'b1};
            if (r_vld[1] && r_sync2) begin
                r_arm <= 1'b1;
            end
        end
    end

    assign w_fall      = r_arm && r_prev && !r_sync2;
    assign w_tick_half = (r_cnt == C_HALF);
    assign w_tick_full = (r_cnt == C_FULL);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        r_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_fall) r_state_next = S_START;
            S_START: if (w_tick_half) r_state_next = r_sync2 ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            S_DATA:   if (w_tick_full && r_idx == 3'd7) r_state_next = S_PARITY;
            S_PARITY: if (w_tick_full) r_state_next = S_STOP;
`else
            S_DATA:   if (w_tick_full && r_idx == 3'd7) r_state_next = S_STOP;
`endif
            S_STOP:  if (w_tick_full) r_state_next = S_IDLE;
            default: r_state_next = S_IDLE;
        endcase
    end

    // FSM outputs: sample strobe, byte completion and error strobes.
    always_comb begin
        w_busy     = (r_state != S_IDLE);
        w_sample   = 1'b0;
        w_push_req = 1'b0;
        w_ferr_set = 1'b0;
        w_perr_set = 1'b0;
        case (r_state)
            S_START: w_sample = w_tick_half;
            S_DATA:  w_sample = w_tick_full;
`ifdef UART_RX_PARITY_EN
            S_PARITY: w_sample = w_tick_full;
`endif
            S_STOP: begin
                w_sample   = w_tick_full;
                w_ferr_set = w_tick_full && !r_sync2;
`ifdef UART_RX_PARITY_EN
                w_push_req = w_tick_full && r_sync2 && !r_par_bad;
                w_perr_set = w_tick_full && r_sync2 && r_par_bad;
`else
                w_push_req = w_tick_full && r_sync2;
`endif
            end
            default: ;
        endcase
    end

    // Bit timer, bit index and data shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_idx  <= 3'd0;
            r_data <= 8'h00;
        end else begin
            if (r_state == S_IDLE || w_sample) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == S_START) begin
                r_idx <= 3'd0;
            end else if (r_state == S_DATA && w_tick_full) begin
                r_data[r_idx] <= r_sync2;
                r_idx         <= r_idx + 3'd1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even-parity check of the assembled byte against the received parity bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_par_bad <= 1'b0;
        end else if (r_state == S_START) begin
            r_par_bad <= 1'b0;
        end else if (r_state == S_PARITY && w_tick_full) begin
            r_par_bad <= (r_sync2 != ^r_data);
        end
    end
`endif

    // FIFO control: a push into a full FIFO only succeeds if a pop frees a slot.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = !w_empty && rready;
    assign w_push  = w_push_req && (!w_full || w_pop);

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= r_data;
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // One-cycle status pulses, asserted the cycle after the stop-bit sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_overrun    <= w_push_req && w_full && !w_pop;
            r_frame_err  <= w_ferr_set;
            r_parity_err <= w_perr_set;
        end
    end

    assign rvalid     = !w_empty;
    assign rdata      = w_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];
    assign busy       = w_busy;
    assign overrun    = r_overrun;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a queue-based reference
// of what the receiver should deliver and which error pulses it should raise.
module tb_uart_rx;

    localparam int CPB   = 8;
    localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Cycles from driving the start bit (just after an edge) to the stop-bit
    // sample edge: 2-flop sync + edge detect, half bit, then the remaining bits.
    localparam int S_LAT = 3 + CPB / 2 + (NBITS - 1) * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       rready = 1'b0;
    logic [7:0] rdata;
    logic       rvalid, busy, overrun, frame_err, parity_err;

    int checks = 0;
    int failures = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int fe_cyc = 0, ov_cyc = 0, pe_cyc = 0, rv_cyc = 0, rdata_bad = 0;

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .rxd(rxd),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .busy(busy), .overrun(overrun), .frame_err(frame_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    // Observe consumer-side transfers and status pulses mid-cycle.
    always @(negedge clk) begin
        if (rvalid && rready) got.push_back(rdata);
        if (!rvalid && rdata !== 8'h00) rdata_bad++;
        if (frame_err) fe_cyc++;
        if (overrun) ov_cyc++;
        if (parity_err) pe_cyc++;
        if (rvalid) rv_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame; line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rxd = ^d;
        tick(CPB);
`endif
        rxd = stop_bit;
        tick(CPB);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_p(input logic [7:0] d, input logic pbit);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            tick(CPB);
        end
        rxd = pbit;
        tick(CPB);
        rxd = 1'b1;
        tick(CPB);
    endtask
`endif

    task automatic compare_rx(input string tag);
        int n;
        chk({tag, ".count"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            $display("rx %s[%0d] got %02h want %02h", tag, i, got[i], exp_q[i]);
            chk($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
        end
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        int fe0, ov0, pe0, rv0, exp_fe, nb, bc;
        logic [7:0] b;
        logic good;

        // Reset state
        tick(3);
        chk("rst.busy", busy, 1'b0);
        chk("rst.rvalid", rvalid, 1'b0);
        chk("rst.rdata", rdata, 8'h00);
        chk("rst.flags", {overrun, frame_err, parity_err}, 3'b000);
        reset = 1'b0;
        tick(2 * CPB);

        // Back-to-back 0x55, 0xA3 then randomized frames with random stop bits
        rready = 1'b1;
        fe0 = fe_cyc; ov0 = ov_cyc; pe0 = pe_cyc; rv0 = rv_cyc;
        send_frame(8'h55, 1'b1); exp_q.push_back(8'h55);
        send_frame(8'hA3, 1'b1); exp_q.push_back(8'hA3);
        exp_fe = 0;
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            send_frame(b, good);
            if (good) begin
                exp_q.push_back(b);
            end else begin
                exp_fe++;
                rxd = 1'b1;
                tick(CPB);
            end
            if ($urandom_range(0, 2) == 0) tick($urandom_range(1, 2 * CPB));
        end
        tick(CPB);
        nb = exp_q.size();
        chk("rand.rvalid_cycles", rv_cyc - rv0, nb);
        compare_rx("rand");
        chk("rand.frame_err", fe_cyc - fe0, exp_fe);
        chk("rand.overrun", ov_cyc - ov0, 0);
        chk("rand.parity_err", pe_cyc - pe0, 0);
        chk("rand.busy_idle", busy, 1'b0);

        // Short glitch: START aborts with no push and no flags
        fe0 = fe_cyc;
        rxd = 1'b0;
        tick(2);
        rxd = 1'b1;
        tick(2);
        chk("glitch.busy_hi", busy, 1'b1);
        tick(CPB);
        chk("glitch.busy_lo", busy, 1'b0);
        chk("glitch.rvalid", rvalid, 1'b0);
        chk("glitch.frame_err", fe_cyc - fe0, 0);
        chk("glitch.pushes", got.size(), 0);

        // Bad stop bit, line held low, then a good frame
        fe0 = fe_cyc;
        send_frame(8'h3C, 1'b0);
        tick(40);
        chk("ferr.pulse", fe_cyc - fe0, 1);
        chk("ferr.busy", busy, 1'b0);
        chk("ferr.nopush", got.size(), 0);
        rxd = 1'b1;
        tick(CPB);
        send_frame(8'h81, 1'b1);
        tick(CPB);
        exp_q.push_back(8'h81);
        compare_rx("ferr");
        chk("ferr.single", fe_cyc - fe0, 1);

        // Overrun: 17 frames into a 16-deep FIFO with no consumer
        rready = 1'b0;
        ov0 = ov_cyc;
        for (int n = 0; n <= DEPTH; n++) begin
            send_frame(8'(n), 1'b1);
            if (n < DEPTH) exp_q.push_back(8'(n));
        end
        tick(CPB);
        chk("ovr.pulse", ov_cyc - ov0, 1);
        chk("ovr.rvalid", rvalid, 1'b1);
        chk("ovr.head", rdata, 8'h00);
        // Full FIFO: pop coincides with the push of the next byte
        fork
            send_frame(8'h11, 1'b1);
            begin
                repeat (S_LAT - 1) @(posedge clk);
                #1 rready = 1'b1;
                @(posedge clk);
                #1 rready = 1'b0;
            end
        join
        exp_q.push_back(8'h11);
        tick(CPB);
        chk("ovr.simul_no_overrun", ov_cyc - ov0, 1);
        chk("ovr.simul_head", rdata, 8'h01);
        rready = 1'b1;
        tick(DEPTH + 4);
        compare_rx("ovr");
        chk("ovr.drained", rvalid, 1'b0);

`ifdef UART_RX_PARITY_EN
        // Parity: good parity accepted, bad parity flagged and dropped
        pe0 = pe_cyc;
        send_frame_p(8'h07, 1'b1);
        tick(CPB);
        exp_q.push_back(8'h07);
        compare_rx("par_ok");
        send_frame_p(8'h07, 1'b0);
        tick(CPB);
        chk("par.pulse", pe_cyc - pe0, 1);
        compare_rx("par_bad");
`endif

        // Reset mid-frame with the line low
        rready = 1'b0;
        send_frame(8'h5A, 1'b1);
        tick(4);
        chk("mrst.pre_rvalid", rvalid, 1'b1);
        chk("mrst.pre_head", rdata, 8'h5A);
        rxd = 1'b0;
        tick(4 * CPB);
        chk("mrst.pre_busy", busy, 1'b1);
        reset = 1'b1;
        tick(1);
        chk("mrst.busy", busy, 1'b0);
        chk("mrst.rvalid", rvalid, 1'b0);
        chk("mrst.rdata", rdata, 8'h00);
        reset = 1'b0;
        bc = 0;
        for (int n = 0; n < 30; n++) begin
            tick(1);
            if (busy) bc++;
        end
        chk("mrst.no_false_start", bc, 0);
        rxd = 1'b1;
        tick(2 * CPB);
        rready = 1'b1;
        got.delete();
        send_frame(8'hF0, 1'b1);
        tick(CPB);
        exp_q.push_back(8'hF0);
        compare_rx("mrst");

        chk("rdata_zero_when_empty", rdata_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
